// File: rtl/lieat_general_radix_4_pkg.sv
// Shared definitions for the radix-4 SRT on-the-fly quotient converter.
//   - One-hot quotient digit bit indices and the matching one-hot codes.
//   - Converter FSM state type.
package lieat_general_radix_4_pkg;

    localparam int unsigned QUOT_ONEHOT_WIDTH = 5;

    // Bit position of each digit inside the one-hot code.
    localparam int unsigned QUOT_NEG_2 = 0;
    localparam int unsigned QUOT_NEG_1 = 1;
    localparam int unsigned QUOT_ZERO  = 2;
    localparam int unsigned QUOT_POS_1 = 3;
    localparam int unsigned QUOT_POS_2 = 4;

    localparam logic [QUOT_ONEHOT_WIDTH-1:0] ONEHOT_NEG_2 = QUOT_ONEHOT_WIDTH'(1) << QUOT_NEG_2;
    localparam logic [QUOT_ONEHOT_WIDTH-1:0] ONEHOT_NEG_1 = QUOT_ONEHOT_WIDTH'(1) << QUOT_NEG_1;
    localparam logic [QUOT_ONEHOT_WIDTH-1:0] ONEHOT_ZERO  = QUOT_ONEHOT_WIDTH'(1) << QUOT_ZERO;
    localparam logic [QUOT_ONEHOT_WIDTH-1:0] ONEHOT_POS_1 = QUOT_ONEHOT_WIDTH'(1) << QUOT_POS_1;
    localparam logic [QUOT_ONEHOT_WIDTH-1:0] ONEHOT_POS_2 = QUOT_ONEHOT_WIDTH'(1) << QUOT_POS_2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONV     = 2'd1,
        WAIT_REM = 2'd2,
        DONE     = 2'd3
    } otfc_state_e;

endpackage

// File: rtl/lieat_general_radix_4_otfc_step.sv
// One on-the-fly conversion step (combinational).
// Ports:
//   q, qm       current quotient and quotient-minus-one (QM == Q-1 mod 2^WIDTH)
//   digit       one-hot quotient digit {-2,-1,0,+1,+2}
//   q_next      updated Q
//   qm_next     updated QM
//   illegal     digit was not one-hot; the step was taken as digit 0
module lieat_general_radix_4_otfc_step
    import lieat_general_radix_4_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]             q,
    input  logic [WIDTH-1:0]             qm,
    input  logic [QUOT_ONEHOT_WIDTH-1:0] digit,
    output logic [WIDTH-1:0]             q_next,
    output logic [WIDTH-1:0]             qm_next,
    output logic                         illegal
);

    logic [WIDTH-3:0] q_low;
    logic [WIDTH-3:0] qm_low;

    assign q_low  = q[WIDTH-3:0];
    assign qm_low = qm[WIDTH-3:0];

    // Positive digits extend Q, negative digits borrow from QM; the new QM is
    // always the new Q minus one so no carry chain is ever needed.
    always_comb begin
        q_next  = {q_low, 2'b00};
        qm_next = {qm_low, 2'b11};
        illegal = 1'b0;
        case (digit)
            ONEHOT_POS_2: begin
                q_next  = {q_low, 2'b10};
                qm_next = {q_low, 2'b01};
            end
            ONEHOT_POS_1: begin
                q_next  = {q_low, 2'b01};
                qm_next = {q_low, 2'b00};
            end
            ONEHOT_ZERO: begin
                q_next  = {q_low, 2'b00};
                qm_next = {qm_low, 2'b11};
            end
            ONEHOT_NEG_1: begin
                q_next  = {qm_low, 2'b11};
                qm_next = {qm_low, 2'b10};
            end
            ONEHOT_NEG_2: begin
                q_next  = {qm_low, 2'b10};
                qm_next = {qm_low, 2'b01};
            end
            default: begin
                // Zero-hot or multi-hot: behave as digit 0 and flag it.
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lieat_general_radix_4_otfc.sv
// Sequential on-the-fly quotient converter for a radix-4 SRT divider.
// Accepts one-hot digits, keeps the Q/QM pair, applies the final remainder
// sign correction and hands the quotient to writeback via valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i, iter_num_i   start a conversion of iter_num_i digits (0 means WIDTH/2)
//   quot_digit_valid_i,
//   quot_digit_i          one-hot digit stream
//   rem_valid_i,
//   rem_neg_i             final remainder sign
//   quot_o, quot_valid_o,
//   quot_ready_i          corrected quotient handshake
//   busy_o                not idle
//   err_o                 sticky illegal-digit flag, cleared on accepted start
module lieat_general_radix_4_otfc
    import lieat_general_radix_4_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = $clog2(WIDTH / 2 + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [CNT_WIDTH-1:0]         iter_num_i,
    input  logic                         quot_digit_valid_i,
    input  logic [QUOT_ONEHOT_WIDTH-1:0] quot_digit_i,
    input  logic                         rem_valid_i,
    input  logic                         rem_neg_i,
    output logic [WIDTH-1:0]             quot_o,
    output logic                         quot_valid_o,
    input  logic                         quot_ready_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam logic [CNT_WIDTH-1:0] FULL_ITER = CNT_WIDTH'(WIDTH / 2);

    otfc_state_e          state_q, state_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     qm_q, qm_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0]     step_q;
    logic [WIDTH-1:0]     step_qm;
    logic                 step_illegal;

    lieat_general_radix_4_otfc_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q_q),
        .qm      (qm_q),
        .digit   (quot_digit_i),
        .q_next  (step_q),
        .qm_next (step_qm),
        .illegal (step_illegal)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                // A digit arriving alongside start is dropped.
                if (start_i) begin
                    state_d = CONV;
                    q_d     = '0;
                    qm_d    = '1;
                    cnt_d   = (iter_num_i == '0) ? FULL_ITER : iter_num_i;
                    err_d   = 1'b0;
                end
            end
            CONV: begin
                if (quot_digit_valid_i) begin
                    q_d   = step_q;
                    qm_d  = step_qm;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (step_illegal) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = WAIT_REM;
                    end
                end
            end
            WAIT_REM: begin
                if (rem_valid_i) begin
                    quot_d  = rem_neg_i ? qm_q : q_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                // start_i is deliberately not looked at here; it must come
                // back once the converter is idle.
                if (quot_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            qm_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            err_q   <= err_d;
        end
    end

    assign quot_o       = quot_q;
    assign quot_valid_o = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_lieat_general_radix_4_otfc.sv
module tb_lieat_general_radix_4_otfc;

    localparam int W   = 32;
    localparam int CW  = 5;
    localparam logic [4:0] DN2 = 5'b00001;
    localparam logic [4:0] DN1 = 5'b00010;
    localparam logic [4:0] DZ  = 5'b00100;
    localparam logic [4:0] DP1 = 5'b01000;
    localparam logic [4:0] DP2 = 5'b10000;

    typedef struct {
        int               iter;
        int               n;
        logic [15:0][4:0] dig;
        logic             neg;
        logic [W-1:0]     q;
        logic             e;
    } rec_t;

    typedef struct {
        logic [W-1:0] quot;
        logic         err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] iter_num_i = '0;
    logic          quot_digit_valid_i = 1'b0;
    logic [4:0]    quot_digit_i = '0;
    logic          rem_valid_i = 1'b0;
    logic          rem_neg_i = 1'b0;
    logic [W-1:0]  quot_o;
    logic          quot_valid_o;
    logic          quot_ready_i = 1'b1;
    logic          busy_o;
    logic          err_o;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    rec_t tbl[8];

    lieat_general_radix_4_otfc #(
        .WIDTH (W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .iter_num_i         (iter_num_i),
        .quot_digit_valid_i (quot_digit_valid_i),
        .quot_digit_i       (quot_digit_i),
        .rem_valid_i        (rem_valid_i),
        .rem_neg_i          (rem_neg_i),
        .quot_o             (quot_o),
        .quot_valid_o       (quot_valid_o),
        .quot_ready_i       (quot_ready_i),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard side: compare whenever a handshake is about to complete.
    always @(negedge clk) begin
        if (rst_n && quot_valid_o && quot_ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result got %h required none", quot_o);
            end else begin
                mon_e = sb.pop_front();
                check("quot", quot_o, mon_e.quot);
                check("err_at_result", W'(err_o), W'(mon_e.err));
            end
        end
    end

    function automatic rec_t mk(int iter, int n, logic [4:0] fill, logic [4:0] d0,
                                logic [4:0] d1, logic [4:0] d2, logic neg,
                                logic [W-1:0] q, logic e);
        rec_t r;
        r.iter = iter;
        r.n    = n;
        r.dig  = {16{fill}};
        if (n <= 3) begin
            r.dig[0] = d0;
            r.dig[1] = d1;
            r.dig[2] = d2;
        end
        r.neg = neg;
        r.q   = q;
        r.e   = e;
        return r;
    endfunction

    // Arithmetic reference: Q = sum d_i * 4^(n-1-i) mod 2^W, minus one if negative remainder.
    function automatic logic [W-1:0] model(rec_t r);
        logic [W-1:0] v = '0;
        int d;
        for (int i = 0; i < r.n; i++) begin
            case (r.dig[i])
                DN2: d = -2;
                DN1: d = -1;
                DP1: d = 1;
                DP2: d = 2;
                default: d = 0;
            endcase
            v = v * 4 + W'(d);
        end
        return v - W'(r.neg);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int iter);
        start_i    = 1'b1;
        iter_num_i = CW'(iter);
        tick();
        start_i = 1'b0;
        check("busy_after_start", W'(busy_o), W'(1));
        check("err_clear_on_start", W'(err_o), W'(0));
    endtask

    task automatic send_digit(input logic [4:0] d);
        quot_digit_valid_i = 1'b1;
        quot_digit_i       = d;
        tick();
        quot_digit_valid_i = 1'b0;
        if (!$onehot(d)) check("err_after_bad_digit", W'(err_o), W'(1));
    endtask

    task automatic send_rem(input logic neg, input logic [W-1:0] q, input logic e);
        exp_t x;
        x.quot = q;
        x.err  = e;
        sb.push_back(x);
        rem_valid_i = 1'b1;
        rem_neg_i   = neg;
        tick();
        rem_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_rec(input rec_t r, input int gap_max);
        do_start(r.iter);
        for (int i = 0; i < r.n; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    quot_digit_i = 5'($urandom);
                    tick();
                end
            end
            send_digit(r.dig[i]);
        end
        send_rem(r.neg, r.q, r.e);
        wait_drain();
    endtask

    initial begin
        logic [W-1:0] held;
        rec_t r;

        tbl[0] = mk(16, 16, DP2, DP2, DP2, DP2, 1'b0, 32'hAAAA_AAAA, 1'b0);
        tbl[1] = mk(3, 3, DZ, DP2, DZ, DN1, 1'b0, 32'd31, 1'b0);
        tbl[2] = mk(3, 3, DZ, DP2, DZ, DN1, 1'b1, 32'd30, 1'b0);
        tbl[3] = mk(0, 16, DP1, DP1, DP1, DP1, 1'b1, 32'h5555_5554, 1'b0);
        tbl[4] = mk(3, 3, DZ, DP2, 5'b00011, DN1, 1'b0, 32'd31, 1'b1);
        tbl[5] = mk(1, 1, DZ, DN2, DZ, DZ, 1'b0, 32'hFFFF_FFFE, 1'b0);
        tbl[6] = mk(2, 2, DZ, DN1, DN2, DZ, 1'b1, 32'hFFFF_FFF9, 1'b0);
        tbl[7] = mk(2, 2, DZ, DP1, 5'b00000, DZ, 1'b0, 32'd4, 1'b1);

        #12;
        check("rst_quot", quot_o, 0);
        check("rst_valid", W'(quot_valid_o), 0);
        check("rst_busy", W'(busy_o), 0);
        check("rst_err", W'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (tbl[k]) run_rec(tbl[k], 0);

        // Two digits with random gaps; a third digit after the count is ignored.
        do_start(2);
        repeat ($urandom_range(3, 1)) begin quot_digit_i = 5'($urandom); tick(); end
        send_digit(DP1);
        repeat ($urandom_range(3, 1)) begin quot_digit_i = 5'($urandom); tick(); end
        send_digit(DN2);
        send_digit(DP2);
        send_rem(1'b0, 32'd2, 1'b0);
        wait_drain();

        // Random legal runs checked against the arithmetic model.
        for (int k = 0; k < 6; k++) begin
            r.n = $urandom_range(16, 1);
            r.iter = (r.n == 16 && k[0]) ? 0 : r.n;
            for (int i = 0; i < 16; i++) r.dig[i] = 5'(1) << $urandom_range(4, 0);
            r.neg = 1'($urandom);
            r.e = 1'b0;
            r.q = model(r);
            run_rec(r, 2);
        end

        // Hold in DONE with ready low; start must be ignored.
        quot_ready_i = 1'b0;
        do_start(3);
        send_digit(DP2);
        send_digit(DZ);
        send_digit(DN1);
        send_rem(1'b1, 32'd30, 1'b0);
        check("valid_latency", W'(quot_valid_o), 1);
        held = quot_o;
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            tick();
            check("hold_quot", quot_o, held);
            check("hold_valid", W'(quot_valid_o), 1);
        end
        quot_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("idle_after_ready_busy", W'(busy_o), 0);
        check("idle_after_ready_valid", W'(quot_valid_o), 0);
        check("hold_scoreboard_empty", W'(sb.size()), 0);

        // Asynchronous reset mid-conversion.
        do_start(16);
        send_digit(DP1);
        send_digit(DP2);
        send_digit(5'b00011);
        send_digit(DN1);
        rst_n = 1'b0;
        #2;
        check("async_rst_quot", quot_o, 0);
        check("async_rst_valid", W'(quot_valid_o), 0);
        check("async_rst_busy", W'(busy_o), 0);
        check("async_rst_err", W'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_rec(mk(1, 1, DZ, DP1, DZ, DZ, 1'b0, 32'd1, 1'b0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
